tx_link_sequencer: RTL and testbench

Octet-level sequencer for the JESD204B transmit link. It sits between the transport source and `tx_link_layer`, which does the 8b/10b encoding. It decides which character goes onto the lane each character-clock cycle:
- K28.5 code-group synchronisation (CGS) while the receiver holds SYNC~ low.
- The four-multiframe initial lane alignment sequence (ILAS), aligned to LMFC.
- User data.

It also detects resynchronisation requests and error reports on SYNC~.

---
 rtl/tx_link_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_tx_link_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_link_sequencer.sv
// -----------------------------------------------------------------------------
// tx_link_sequencer
//
// Octet-level sequencer for a JESD204B transmit lane. It sits in front of the
// 8b/10b encoder and chooses the character for each character-clock cycle:
// K28.5 during code-group synchronisation, the LMFC-aligned initial lane
// alignment sequence, and then user data. It also watches SYNC~ for resync
// requests (long low runs) and error reports (short low runs).
//
// Ports
//   clk          character clock
//   rst          asynchronous, active-high reset
//   i_syncn      SYNC~ from the receiver, already in the clk domain (low = request)
//   i_lmfc_edge  one-cycle pulse on the cycle before each LMFC boundary
//   i_cfg        ILAS configuration octets 0..13, octet n at [8n+7:8n]
//   i_data       user octet
//   i_vld        i_data is valid
//   o_data       octet to the link layer
//   o_k          o_data is a control character
//   o_ready      sequencer is in DATA and consumes i_data
//   o_state      0 = CGS, 1 = ILAS, 2 = DATA
//   o_err        one-cycle pulse on a short SYNC~ error report
// -----------------------------------------------------------------------------
module tx_link_sequencer #(
    parameter int F          = 1,
    parameter int K          = 32,
    parameter int ILAS_MF    = 4,
    parameter int RESYNC_LEN = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_syncn,
    input  logic         i_lmfc_edge,
    input  logic [111:0] i_cfg,
    input  logic [7:0]   i_data,
    input  logic         i_vld,
    output logic [7:0]   o_data,
    output logic         o_k,
    output logic         o_ready,
    output logic [1:0]   o_state,
    output logic         o_err
);

    typedef enum logic [1:0] {
        ST_CGS  = 2'd0,
        ST_ILAS = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    // F*K is at most 1024, so a 10-bit octet counter covers every legal frame size.
    localparam int OC_W = 10;
    localparam int MF_W = (ILAS_MF > 1) ? $clog2(ILAS_MF) : 1;
    localparam int LC_W = $clog2(RESYNC_LEN + 1);

    localparam logic [OC_W-1:0] OC_LAST = OC_W'(F * K - 1);
    localparam logic [MF_W-1:0] MF_LAST = MF_W'(ILAS_MF - 1);
    localparam logic [MF_W-1:0] MF_ONE  = MF_W'(1);
    localparam logic [LC_W-1:0] LC_TRIG = LC_W'(RESYNC_LEN - 1);

    localparam logic [7:0] K_28_5 = 8'hBC;
    localparam logic [7:0] K_R    = 8'h1C;
    localparam logic [7:0] K_A    = 8'h7C;
    localparam logic [7:0] K_Q    = 8'h9C;

    state_e          state_q, state_d;
    logic [OC_W-1:0] oc_q, oc_d;
    logic [MF_W-1:0] mf_q, mf_d;
    logic [LC_W-1:0] lc_q, lc_d;
    logic            syncn_hi_q, syncn_hi_d;
    logic [7:0]      data_q, data_d;
    logic            k_q, k_d;
    logic            ready_q, ready_d;
    logic            err_q, err_d;

    logic            oc_last;
    logic [127:0]    cfg_pad;

    assign oc_last = (oc_q == OC_LAST);
    // Padding lets a 4-bit octet index address the table without running off the end.
    assign cfg_pad = {16'h0000, i_cfg};

    // Next-state logic: sequencing, counters and the SYNC~ monitor.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        state_d    = state_q;
        oc_d       = oc_q;
        mf_d       = mf_q;
        lc_d       = lc_q;
        syncn_hi_d = syncn_hi_q;
        err_d      = 1'b0;

        case (state_q)
            ST_ILAS: begin
                if (oc_last) begin
                    oc_d = '0;
                    if (mf_q == MF_LAST) begin
                        state_d = ST_DATA;
                        mf_d    = '0;
                    end else begin
                        mf_d = mf_q + 1'b1;
                    end
                end else begin
                    oc_d = oc_q + 1'b1;
                end
            end
            ST_DATA: begin
                oc_d = oc_last ? '0 : oc_q + 1'b1;
            end
            default: begin
                // CGS, and the unused encoding which falls back to CGS.
                state_d    = ST_CGS;
                syncn_hi_d = i_syncn;
                lc_d       = '0;
                oc_d       = '0;
                mf_d       = '0;
                // The registered flag is used, so a SYNC~ rising in the LMFC cycle itself is too late.
                if (syncn_hi_q && i_lmfc_edge) begin
                    state_d = ST_ILAS;
                end
            end
        endcase

        // The monitor is evaluated last so a resync overrides the ILAS->DATA step.
        if (state_q == ST_ILAS || state_q == ST_DATA) begin
            if (!i_syncn) begin
                lc_d = lc_q + 1'b1;
                if (lc_q == LC_TRIG) begin
                    state_d    = ST_CGS;
                    oc_d       = '0;
                    mf_d       = '0;
                    syncn_hi_d = 1'b0;
                end
            end else begin
                lc_d  = '0;
                err_d = (lc_q != '0);
            end
        end
    end

    // Output decode from the next state, so the registered octet lines up with the state it belongs to.
    always_comb begin
        logic [3:0] cfg_idx;
        logic       cfg_slot;

        cfg_idx  = oc_d[3:0] - 4'd2;
        cfg_slot = (oc_d[OC_W-1:4] == '0) && (oc_d[3:1] != 3'b000);
        data_d   = K_28_5;
        k_d      = 1'b1;
        ready_d  = 1'b0;

        case (state_d)
            ST_ILAS: begin
                if (oc_d == '0) begin
                    data_d = K_R;
                end else if (oc_d == OC_LAST) begin
                    data_d = K_A;
                end else if (mf_d == MF_ONE && oc_d == OC_W'(1)) begin
                    data_d = K_Q;
                end else if (mf_d == MF_ONE && cfg_slot) begin
                    data_d = cfg_pad[{cfg_idx, 3'b000} +: 8];
                    k_d    = 1'b0;
                end else begin
                    data_d = oc_d[7:0];
                    k_d    = 1'b0;
                end
            end
            ST_DATA: begin
                ready_d = 1'b1;
                k_d     = 1'b0;
                // Only octets offered while o_ready was already high are consumed.
                data_d  = (ready_q && i_vld) ? i_data : 8'h00;
            end
            default: begin
                data_d = K_28_5;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_CGS;
            oc_q       <= '0;
            mf_q       <= '0;
            lc_q       <= '0;
            syncn_hi_q <= 1'b0;
            data_q     <= K_28_5;
            k_q        <= 1'b1;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            oc_q       <= oc_d;
            mf_q       <= mf_d;
            lc_q       <= lc_d;
            syncn_hi_q <= syncn_hi_d;
            data_q     <= data_d;
            k_q        <= k_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
        end
    end

    assign o_data  = data_q;
    assign o_k     = k_q;
    assign o_ready = ready_q;
    assign o_state = state_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_tx_link_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tx_link_sequencer
//
// Directed-plus-random bench for tx_link_sequencer. A behavioural model tracks
// the link as a mode plus a flat ILAS position (multiframe/octet derived by
// division) and a SYNC~ low-run length, and predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_tx_link_sequencer;

    localparam int F          = 1;
    localparam int K          = 32;
    localparam int ILAS_MF    = 4;
    localparam int RESYNC_LEN = 8;
    localparam int FK         = F * K;
    localparam int ILAS_LEN   = ILAS_MF * FK;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_syncn = 1'b0;
    logic         i_lmfc_edge = 1'b0;
    logic [111:0] i_cfg = 112'h0D0C0B0A09080706050403020100;
    logic [7:0]   i_data = 8'h00;
    logic         i_vld = 1'b0;
    logic [7:0]   o_data;
    logic         o_k;
    logic         o_ready;
    logic [1:0]   o_state;
    logic         o_err;

    tx_link_sequencer #(
        .F(F), .K(K), .ILAS_MF(ILAS_MF), .RESYNC_LEN(RESYNC_LEN)
    ) dut (
        .clk(clk), .rst(rst), .i_syncn(i_syncn), .i_lmfc_edge(i_lmfc_edge),
        .i_cfg(i_cfg), .i_data(i_data), .i_vld(i_vld),
        .o_data(o_data), .o_k(o_k), .o_ready(o_ready), .o_state(o_state), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit extra_lmfc = 1'b0;

    // Reference model: 0 = CGS, 1 = ILAS, 2 = DATA.
    int   m_mode, m_pos, m_low;
    bit   m_hi;
    logic [7:0] e_data;
    logic       e_k, e_ready, e_err;
    logic [1:0] e_state;

    // Observations used for the timing checks.
    int first_r, first_a, ready_rise, err_seen;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_low = 0; m_hi = 1'b0;
        e_data = 8'hBC; e_k = 1'b1; e_ready = 1'b0; e_state = 2'd0; e_err = 1'b0;
    endtask

    task automatic model_step(input bit syncn, input bit lmfc, input logic [7:0] d, input bit v);
        int prev, oc, mf;
        logic [111:0] sh;
        prev  = m_mode;
        e_err = 1'b0;
        if (prev == 0) begin
            if (m_hi && lmfc) begin
                m_mode = 1;
                m_pos  = 0;
            end
            m_hi = syncn;
        end else if (prev == 1) begin
            if (m_pos == ILAS_LEN - 1) m_mode = 2;
            else m_pos++;
        end
        if (prev != 0) begin
            if (!syncn) begin
                m_low++;
                if (m_low >= RESYNC_LEN) begin
                    m_mode = 0;
                    m_hi   = 1'b0;
                    m_low  = 0;
                end
            end else begin
                e_err = (m_low > 0);
                m_low = 0;
            end
        end
        e_state = 2'(m_mode);
        e_ready = (m_mode == 2);
        e_k     = 1'b0;
        case (m_mode)
            1: begin
                oc = m_pos % FK;
                mf = m_pos / FK;
                if (oc == 0) begin
                    e_data = 8'h1C; e_k = 1'b1;
                end else if (oc == FK - 1) begin
                    e_data = 8'h7C; e_k = 1'b1;
                end else if (mf == 1 && oc == 1) begin
                    e_data = 8'h9C; e_k = 1'b1;
                end else if (mf == 1 && oc >= 2 && oc <= 15) begin
                    sh = i_cfg >> (8 * (oc - 2));
                    e_data = sh[7:0];
                end else begin
                    e_data = 8'(oc);
                end
            end
            2: e_data = (prev == 2 && v) ? d : 8'h00;
            default: begin
                e_data = 8'hBC; e_k = 1'b1;
            end
        endcase
    endtask

    task automatic compare_all();
        check("o_data",  16'(o_data),  16'(e_data));
        check("o_k",     16'(o_k),     16'(e_k));
        check("o_ready", 16'(o_ready), 16'(e_ready));
        check("o_state", 16'(o_state), 16'(e_state));
        check("o_err",   16'(o_err),   16'(e_err));
    endtask

    // One character cycle: present inputs, clock, update model, sample #1 later.
    task automatic tick();
        bit s, l, v;
        logic [7:0] d;
        i_lmfc_edge = ((cyc % 32) == 20) || extra_lmfc;
        s = i_syncn; l = i_lmfc_edge; d = i_data; v = i_vld;
        @(posedge clk);
        if (rst) model_reset();
        else model_step(s, l, d, v);
        #1;
        compare_all();
        if (first_r < 0 && o_data === 8'h1C && o_k === 1'b1) first_r = cyc + 1;
        if (first_a < 0 && o_data === 8'h7C && o_k === 1'b1) first_a = cyc + 1;
        if (ready_rise < 0 && o_ready === 1'b1) ready_rise = cyc + 1;
        if (o_err === 1'b1) err_seen++;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int low_left;
        model_reset();
        first_r = -1; first_a = -1; ready_rise = -1; err_seen = 0;

        // Reset held with wiggling inputs.
        for (int n = 0; n < 8; n++) begin
            i_syncn = 1'($urandom); i_data = 8'($urandom); i_vld = 1'($urandom);
            extra_lmfc = 1'($urandom);
            tick();
        end
        extra_lmfc = 1'b0;
        i_syncn = 1'b0; i_vld = 1'b0;
        rst = 1'b0;
        cyc = 0;
        first_r = -1; first_a = -1; ready_rise = -1;

        // CGS -> ILAS -> DATA; a stray LMFC at cycle 5 with SYNC~ low must not start ILAS.
        for (int n = 0; n < 400 && o_ready !== 1'b1; n++) begin
            i_syncn    = (cyc >= 10);
            extra_lmfc = (cyc == 5);
            i_data     = 8'($urandom);
            tick();
        end
        extra_lmfc = 1'b0;
        check("ready_timeout", 16'(o_ready), 16'd1);
        check("first_R_cycle", 16'(first_r), 16'd21);
        check("first_A_cycle", 16'(first_a), 16'd52);
        check("ready_rise_cycle", 16'(ready_rise), 16'd149);
        check("ilas_length", 16'(ready_rise - first_r), 16'(ILAS_LEN));

        // Data ramp, then three idle cycles, then random traffic.
        for (int n = 0; n < 8; n++) begin
            i_data = 8'hA0 + 8'(n); i_vld = 1'b1;
            tick();
        end
        for (int n = 0; n < 4; n++) begin
            i_data = 8'($urandom); i_vld = 1'b0;
            tick();
        end
        for (int n = 0; n < 30; n++) begin
            i_data = 8'($urandom); i_vld = 1'($urandom) & o_ready;
            tick();
        end

        // Short low run: one error pulse, state stays DATA.
        err_seen = 0;
        i_vld = 1'b0;
        i_syncn = 1'b0;
        repeat (3) tick();
        i_syncn = 1'b1;
        repeat (3) tick();
        check("err_pulse_count", 16'(err_seen), 16'd1);
        check("state_after_err", 16'(o_state), 16'd2);

        // Full-length low run: resync to CGS, no error pulse.
        err_seen = 0;
        i_syncn = 1'b0;
        repeat (RESYNC_LEN) tick();
        check("resync_state", 16'(o_state), 16'd0);
        check("resync_data", 16'(o_data), 16'hBC);
        i_syncn = 1'b1;
        repeat (2) tick();
        check("resync_no_err", 16'(err_seen), 16'd0);

        // Random SYNC~ low runs, data and occasional stray LMFC pulses.
        low_left = 0;
        for (int n = 0; n < 700; n++) begin
            if (low_left > 0) begin
                i_syncn = 1'b0;
                low_left--;
            end else begin
                i_syncn = 1'b1;
                if ($urandom_range(0, 19) == 0) low_left = $urandom_range(1, 10);
            end
            extra_lmfc = ($urandom_range(0, 49) == 0);
            i_data = 8'($urandom);
            i_vld  = 1'($urandom) & o_ready;
            tick();
        end
        extra_lmfc = 1'b0;
        i_vld = 1'b0;

        // Mid-ILAS asynchronous reset at ILAS octet 40.
        i_syncn = 1'b0;
        repeat (RESYNC_LEN + 2) tick();
        i_syncn = 1'b1;
        for (int n = 0; n < 300 && !(m_mode == 1 && m_pos == 40); n++) tick();
        check("ilas_octet40_state", 16'(o_state), 16'd1);
        check("ilas_octet40_data", 16'(o_data), 16'h06);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        repeat (3) tick();
        rst = 1'b0;

        // Resync whose final low sample lands on the last ILAS octet wins over DATA entry.
        i_syncn = 1'b1;
        for (int n = 0; n < 400 && !(m_mode == 1 && m_pos == ILAS_LEN - RESYNC_LEN); n++) tick();
        check("reach_ilas_tail", 16'(m_pos), 16'(ILAS_LEN - RESYNC_LEN));
        i_syncn = 1'b0;
        repeat (RESYNC_LEN) tick();
        check("resync_priority_state", 16'(o_state), 16'd0);
        check("resync_priority_ready", 16'(o_ready), 16'd0);

        // ILAS restarts on a later LMFC edge and reaches DATA again.
        i_syncn = 1'b1;
        for (int n = 0; n < 400 && o_ready !== 1'b1; n++) tick();
        check("relink_ready", 16'(o_ready), 16'd1);
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
